// File: rtl/sram_responder_pkg.sv
// Shared types for the buffer-memory responder: host-burst FSM states and stall counter width.
package sram_responder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    RD_DRAIN = 2'd3
  } resp_state_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sram_responder_fifo2_skid.sv
// Two-entry valid/ready FIFO for host read data; push visible at the head the next cycle.
// Pushes are dropped when full (the issuer reserves room); the head is held while pop_rdy_i is low.
module fifo2_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              push_vld_i,
  input  logic [DATA_W-1:0] push_dat_i,
  output logic              pop_vld_o,
  input  logic              pop_rdy_i,
  output logic [DATA_W-1:0] pop_dat_o,
  output logic [1:0]        cnt_o
);

  logic [DATA_W-1:0] ent_q [2];
  logic              wptr_q;
  logic              rptr_q;
  logic [1:0]        cnt_q;
  logic              push;
  logic              pop;

  assign push      = push_vld_i && (cnt_q != 2'd2);
  assign pop       = pop_rdy_i && (cnt_q != 2'd0);
  assign pop_vld_o = (cnt_q != 2'd0);
  assign pop_dat_o = ent_q[rptr_q];
  assign cnt_o     = cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        ent_q[wptr_q] <= push_dat_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Single-port buffer with 1-cycle DUT read plus a host burst port that stalls whenever the DUT accesses.
// Optional SRAM_RESPONDER_STALL_CNT_EN adds stall_cnt_o, a saturating count of host-blocked cycles.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = WIDTH * LANES
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              mem_cenb_i,
  input  logic              mem_wenb_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [ADDR_W-1:0] cmd_len_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  input  logic              rd_ready_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              cmd_done_o
`ifdef SRAM_RESPONDER_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_rdata_q;
  logic [DATA_W-1:0] rd_word_q;
  resp_state_e       state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] rem_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] ptr_nxt;
  logic [1:0]        fifo_cnt;
  logic              fifo_vld;
  logic              dut_acc;
  logic              dut_in_range;
  logic              ptr_in_range;
  logic              fifo_room;
  logic              host_wr;
  logic              host_rd;
  logic              last_pop;

  assign dut_acc      = !mem_cenb_i;
  assign dut_in_range = {1'b0, mem_addr_i} < DEPTH_X;
  assign ptr_in_range = {1'b0, ptr_q} < DEPTH_X;
  // In-flight reads count against FIFO space so a pushed word always fits.
  assign fifo_room    = (fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && !inflight_q);
  assign ptr_nxt      = (ptr_q == LAST_ADDR) ? '0 : ptr_q + 1'b1;

  assign cmd_ready_o = (state_q == IDLE);
  assign wr_ready_o  = (state_q == WR_BURST) && mem_cenb_i;
  assign host_wr     = wr_ready_o && wr_valid_i;
  assign host_rd     = (state_q == RD_BURST) && mem_cenb_i && fifo_room;
  assign rd_valid_o  = fifo_vld;
  assign last_pop    = (state_q == RD_DRAIN) && fifo_vld && rd_ready_i &&
                       (fifo_cnt == 2'd1) && !inflight_q;
  assign cmd_done_o  = (host_wr && (rem_q == '0)) || last_pop;
  assign mem_data_o  = mem_rdata_q;

  always_ff @(posedge clk_i) begin
    if (dut_acc && !mem_wenb_i && dut_in_range) mem_q[mem_addr_i] <= mem_data_i;
    else if (host_wr && ptr_in_range)           mem_q[ptr_q]      <= wr_data_i;
    if (host_rd) rd_word_q <= ptr_in_range ? mem_q[ptr_q] : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) mem_rdata_q <= '0;
    else if (dut_acc && mem_wenb_i) mem_rdata_q <= dut_in_range ? mem_q[mem_addr_i] : '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= host_rd;
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          ptr_q   <= cmd_addr_i;
          rem_q   <= cmd_len_i;
          state_q <= cmd_we_i ? WR_BURST : RD_BURST;
        end
        WR_BURST: if (host_wr) begin
          ptr_q <= ptr_nxt;
          rem_q <= rem_q - 1'b1;
          if (rem_q == '0) state_q <= IDLE;
        end
        RD_BURST: if (host_rd) begin
          ptr_q <= ptr_nxt;
          rem_q <= rem_q - 1'b1;
          if (rem_q == '0) state_q <= RD_DRAIN;
        end
        RD_DRAIN: if (last_pop) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  fifo2_skid #(.DATA_W(DATA_W)) u_rd_fifo (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .push_vld_i (inflight_q),
    .push_dat_i (rd_word_q),
    .pop_vld_o  (fifo_vld),
    .pop_rdy_i  (rd_ready_i),
    .pop_dat_o  (rd_data_o),
    .cnt_o      (fifo_cnt)
  );

`ifdef SRAM_RESPONDER_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   host_blocked;

  assign host_blocked = dut_acc && (((state_q == WR_BURST) && wr_valid_i) ||
                                    ((state_q == RD_BURST) && fifo_room));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) stall_cnt_q <= '0;
    else if (cmd_ready_o && cmd_valid_i) stall_cnt_q <= '0;
    else if (host_blocked && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
